// File: rtl/data_4x4_untransform_stream_if.sv
// Block-in / row-out stream bundle for the 4x4 untransform stage.
// slave is the stage itself, master is the surrounding environment.
interface data_4x4_untransform_stream_if #(
  parameter int W = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [16*W-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [4*W-1:0]  out_data;
  logic [1:0]      out_row;
  logic            out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_row, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_last
  );
endinterface

// File: rtl/data_4x4_untransform_stream.sv
// Restores row-major order of a transposed 4x4 block and streams it
// out as four row words; one-block buffer, back-to-back on last beat.
module data_4x4_untransform_stream #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  data_4x4_untransform_stream_if.slave bus,
  output logic [CNT_W-1:0] blk_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      row_q, row_d;
  logic [16*W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] blk_q, blk_d;

  logic           in_ready;
  logic           out_valid;
  logic           last_row;
  logic [4*W-1:0] row_word;
  logic [W-1:0]   t [4][4];

  // Unpack the buffered transposed block into T[r][c], MSB element first
  for (genvar r = 0; r < 4; r++) begin : g_r
    for (genvar c = 0; c < 4; c++) begin : g_c
      assign t[r][c] = buf_q[16*W-1-W*(4*r+c) -: W];
    end
  end

  // Row word r gathers column r of T, i.e. M[r][c] = T[c][r]
  always_comb begin
    row_word = '0;
    for (int k = 0; k < 4; k++) begin
      row_word[4*W-1-W*k -: W] = t[k][row_q];
    end
  end

  assign last_row  = (row_q == 2'd3);
  assign out_valid = (state_q == SEND);
  // Combinational out_ready -> in_ready path lets a new block land
  // on the final row beat without a bubble.
  assign in_ready  = (state_q == IDLE) |
                     (out_valid & last_row & bus.out_ready);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? row_word : '0;
  assign bus.out_row   = out_valid ? row_q : 2'd0;
  assign bus.out_last  = out_valid & last_row;
  assign blk_cnt       = blk_q;

  // Next-state: capture, row advance, block completion
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    buf_d   = buf_q;
    blk_d   = blk_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          buf_d   = bus.in_data;
          row_d   = 2'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          if (last_row) begin
            blk_d = blk_q + 1'b1;
            row_d = 2'd0;
            if (bus.in_valid) begin
              buf_d   = bus.in_data;
              state_d = SEND;
            end else begin
              state_d = IDLE;
            end
          end else begin
            row_d = row_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= 2'd0;
      buf_q   <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      buf_q   <= buf_d;
      blk_q   <= blk_d;
    end
  end

endmodule

// File: tb/tb_data_4x4_untransform_stream.sv
// Directed bench for data_4x4_untransform_stream.
// A second instance with CNT_W=2 shares all stimulus for wrap checks.
module tb_data_4x4_untransform_stream;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic out_ready;
  logic [16*W-1:0] in_data;
  logic [15:0] blk_cnt;
  logic [1:0]  blk_cnt2;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] BLK1 =
    128'h01020304_01020304_01020304_01020304;
  localparam logic [127:0] BLK_A =
    128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLK_B =
    128'hF0E0D0C0_B0A09080_70605040_30201000;

  data_4x4_untransform_stream_if #(.W(W)) bus ();
  data_4x4_untransform_stream_if #(.W(W)) bus2 ();

  assign bus.in_valid   = in_valid;
  assign bus.in_data    = in_data;
  assign bus.out_ready  = out_ready;
  assign bus2.in_valid  = in_valid;
  assign bus2.in_data   = in_data;
  assign bus2.out_ready = out_ready;

  data_4x4_untransform_stream #(.W(W), .CNT_W(16)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .blk_cnt (blk_cnt)
  );

  data_4x4_untransform_stream #(.W(W), .CNT_W(2)) u_wrap (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus2.slave),
    .blk_cnt (blk_cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_row(input string tag,
                         input logic [31:0] data,
                         input logic [1:0] row,
                         input logic rdy);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_data"}, 64'(bus.out_data), 64'(data));
    chk({tag, "_row"}, 64'(bus.out_row), 64'(row));
    chk({tag, "_last"}, 64'(bus.out_last), 64'(row == 2'd3));
    chk({tag, "_inrdy"}, 64'(bus.in_ready), 64'(rdy));
  endtask

  logic [31:0] a_rows [4];
  logic [31:0] b_rows [4];
  logic [31:0] s_rows [4];
  logic        bp_rdy [7];
  logic [1:0]  bp_row [7];
  logic [1:0]  wrap_exp [5];
  int          beats;
  int          exp_blk;

  initial begin
    a_rows = '{32'h004488CC, 32'h115599DD, 32'h2266AAEE, 32'h3377BBFF};
    b_rows = '{32'hF0B07030, 32'hE0A06020, 32'hD0905010, 32'hC0804000};
    s_rows = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};
    bp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bp_row = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = BLK_A;
    out_ready = 1'b1;

    // Reset dominates an offered block
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_inrdy", 64'(bus.in_ready), 64'd1);
      chk("rst_blk", 64'(blk_cnt), 64'd0);
      chk("rst_data", 64'(bus.out_data), 64'd0);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    step();
    chk("idle_valid", 64'(bus.out_valid), 64'd0);

    // Single block, continuous out_ready
    in_valid = 1'b1;
    in_data  = BLK1;
    chk("s_accept", 64'(bus.in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    in_data  = BLK_B;
    for (int r = 0; r < 4; r++) begin
      chk_row("single", s_rows[r], 2'(r), r == 3);
      step();
    end
    chk("s_idle", 64'(bus.out_valid), 64'd0);
    chk("s_blk", 64'(blk_cnt), 64'd1);
    chk("s_last0", 64'(bus.out_last), 64'd0);
    chk("s_data0", 64'(bus.out_data), 64'd0);

    // Backpressure
    in_valid = 1'b1;
    in_data  = BLK1;
    step();
    in_valid = 1'b0;
    beats    = 0;
    for (int i = 0; i < 7; i++) begin
      out_ready = bp_rdy[i];
      #1;
      chk_row("bp", s_rows[bp_row[i]], bp_row[i],
              bp_rdy[i] && bp_row[i] == 2'd3);
      if (bus.out_valid && out_ready) beats++;
      step();
    end
    out_ready = 1'b1;
    chk("bp_beats", 64'(beats), 64'd4);
    chk("bp_idle", 64'(bus.out_valid), 64'd0);
    chk("bp_blk", 64'(blk_cnt), 64'd2);

    // Back-to-back blocks A then B
    in_valid = 1'b1;
    in_data  = BLK_A;
    step();
    in_data  = BLK_B;
    for (int r = 0; r < 4; r++) begin
      chk_row("a", a_rows[r], 2'(r), r == 3);
      step();
    end
    in_valid = 1'b0;
    chk("b2b_blk", 64'(blk_cnt), 64'd3);
    for (int r = 0; r < 4; r++) begin
      chk_row("b", b_rows[r], 2'(r), r == 3);
      step();
    end
    chk("b2b_idle", 64'(bus.out_valid), 64'd0);
    chk("b2b_blk2", 64'(blk_cnt), 64'd4);

    // Reset in the middle of a block
    in_valid = 1'b1;
    in_data  = BLK_A;
    step();
    in_valid = 1'b0;
    chk_row("m0", a_rows[0], 2'd0, 1'b0);
    step();
    chk_row("m1", a_rows[1], 2'd1, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_valid", 64'(bus.out_valid), 64'd0);
    chk("mr_blk", 64'(blk_cnt), 64'd0);
    chk("mr_inrdy", 64'(bus.in_ready), 64'd1);
    chk("mr_row", 64'(bus.out_row), 64'd0);
    in_valid = 1'b1;
    in_data  = BLK_B;
    step();
    in_valid = 1'b0;
    for (int r = 0; r < 4; r++) begin
      chk_row("mb", b_rows[r], 2'(r), r == 3);
      step();
    end
    chk("mb_blk", 64'(blk_cnt), 64'd1);

    // Counter wrap on the CNT_W=2 instance
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("w_rst", 64'(blk_cnt2), 64'd0);
    exp_blk = 0;
    for (int b = 0; b < 5; b++) begin
      in_valid = 1'b1;
      in_data  = (b % 2 == 0) ? BLK_A : BLK_B;
      step();
      in_valid = 1'b0;
      for (int r = 0; r < 4; r++) begin
        chk("w_data", 64'(bus2.out_data),
            64'((b % 2 == 0) ? a_rows[r] : b_rows[r]));
        step();
      end
      exp_blk++;
      chk("w_cnt2", 64'(blk_cnt2), 64'(wrap_exp[b]));
      chk("w_cnt16", 64'(blk_cnt), 64'(exp_blk));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
